// File: rtl/pill_feeder.sv
// Pill pulse generator: paces isWork pulses into each bottle, dwells for bottle
// changes and keeps BCD tallies of pills in the current bottle and bottles completed.
module pill_feeder #(
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned CHG_CYC = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       EN_work,
    input  logic       conti,
    input  logic       allFull,
    input  logic [3:0] maxL,
    input  logic [3:0] maxH,
    input  logic [3:0] botL,
    input  logic [3:0] botH,
    output logic       isWork,
    output logic [3:0] pillL,
    output logic [3:0] pillH,
    output logic [3:0] bottleL,
    output logic [3:0] bottleH,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BCD_W = 8;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CHG_LAST   = CNT_W'(CHG_CYC - 1);
    localparam logic [BCD_W-1:0] BCD_ONE    = BCD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_GAP,
        S_CHANGE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] max_q, max_d;
    logic [BCD_W-1:0] bot_q, bot_d;
    logic [BCD_W-1:0] pill_q, pill_d;
    logic [BCD_W-1:0] bottle_q, bottle_d;
    logic             chg_wait_q, chg_wait_d;
    logic             chg_go_q, chg_go_d;
    logic             conti_prev_q;
    logic             is_work_q, is_work_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_bad_c;
    logic             chg_exit_c;
    logic [BCD_W-1:0] bottle_inc_c;

    // Two-digit BCD increment; callers guarantee the value stays below 99.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign cfg_bad_c = (maxL > 4'd9) || (maxH > 4'd9) || (botL > 4'd9) || (botH > 4'd9)
                     || ({maxH, maxL} == 8'h00) || ({botH, botL} == 8'h00);
    assign bottle_inc_c = bcd_inc(bottle_q);

    // Next-state, timers, tallies and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        bot_d      = bot_q;
        pill_d     = pill_q;
        bottle_d   = bottle_q;
        chg_wait_d = chg_wait_q;
        chg_go_d   = chg_go_q;
        is_work_d  = 1'b0;
        chg_exit_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (EN_work && !cfg_bad_c) begin
                    state_d   = S_FEED;
                    max_d     = {maxH, maxL};
                    bot_d     = {botH, botL};
                    pill_d    = BCD_ONE;
                    bottle_d  = '0;
                    cnt_d     = '0;
                    is_work_d = 1'b1;
                end
            end
            S_FEED: begin
                if (!EN_work) begin
                    cnt_d = '0;
                end else if (!is_work_q) begin
                    // resuming after a pause: restart the pulse, tally already counted
                    is_work_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    is_work_d = 1'b1;
                end
            end
            S_GAP: begin
                if (EN_work) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (pill_q == max_q) begin
                            state_d    = S_CHANGE;
                            chg_wait_d = !conti;
                            chg_go_d   = 1'b0;
                        end else begin
                            state_d   = S_FEED;
                            pill_d    = bcd_inc(pill_q);
                            is_work_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CHANGE: begin
                if (EN_work) begin
                    if (chg_wait_q) begin
                        if (chg_go_q) begin
                            chg_exit_c = 1'b1;
                        end else if (conti && !conti_prev_q) begin
                            chg_go_d = 1'b1;
                        end
                    end else if (cnt_q == CHG_LAST) begin
                        chg_exit_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!EN_work) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (chg_exit_c) begin
            cnt_d    = '0;
            chg_go_d = 1'b0;
            bottle_d = bottle_inc_c;
            if (bottle_inc_c == bot_q) begin
                state_d = S_DONE;
                pill_d  = '0;
            end else begin
                state_d   = S_FEED;
                pill_d    = BCD_ONE;
                is_work_d = 1'b1;
            end
        end

        // allFull overrides pause and every transition, freezing the tallies
        if (allFull && (state_q != S_IDLE)) begin
            state_d   = S_DONE;
            is_work_d = 1'b0;
            cnt_d     = cnt_q;
            pill_d    = pill_q;
            bottle_d  = bottle_q;
            chg_go_d  = chg_go_q;
        end

        busy_d    = (state_d == S_FEED) || (state_d == S_GAP) || (state_d == S_CHANGE);
        done_d    = (state_d == S_DONE);
        cfg_err_d = (state_d == S_IDLE) && cfg_bad_c;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            bot_q        <= '0;
            pill_q       <= '0;
            bottle_q     <= '0;
            chg_wait_q   <= 1'b0;
            chg_go_q     <= 1'b0;
            conti_prev_q <= 1'b0;
            is_work_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            bot_q        <= bot_d;
            pill_q       <= pill_d;
            bottle_q     <= bottle_d;
            chg_wait_q   <= chg_wait_d;
            chg_go_q     <= chg_go_d;
            conti_prev_q <= conti;
            is_work_q    <= is_work_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign isWork  = is_work_q;
    assign pillL   = pill_q[3:0];
    assign pillH   = pill_q[7:4];
    assign bottleL = bottle_q[3:0];
    assign bottleH = bottle_q[7:4];
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pill_feeder.sv
// Testbench for pill_feeder: closed-form timing model for free-running batches
// plus directed scenarios for bottle-change handshake, pause, allFull, cfg errors, reset.
module tb_pill_feeder;

    localparam int P = 1;
    localparam int G = 4;
    localparam int C = 8;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       EN_work;
    logic       conti;
    logic       allFull;
    logic [3:0] maxL, maxH, botL, botH;
    logic       isWork;
    logic [3:0] pillL, pillH, bottleL, bottleH;
    logic       busy, done, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    pill_feeder dut (
        .CLK(CLK), .RST_n(RST_n), .EN_work(EN_work), .conti(conti), .allFull(allFull),
        .maxL(maxL), .maxH(maxH), .botL(botL), .botH(botH),
        .isWork(isWork), .pillL(pillL), .pillH(pillH), .bottleL(bottleL), .bottleH(bottleH),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int m, input int b);
        {maxH, maxL} = to_bcd(m);
        {botH, botL} = to_bcd(b);
    endtask

    task automatic go_idle();
        EN_work = 1'b0;
        allFull = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_done_busy", 32'({done, busy}), 32'h0);
    endtask

    // Free-running batch with conti=1; expectation from pure cycle arithmetic.
    task automatic run_model(input int m, input int b, input string tag);
        int L, total, u, bi, r, exp_pill, exp_bot, pulses;
        logic exp_iw, exp_done, exp_busy, prev_iw;
        logic [18:0] exp_v, obs_v;
        L      = m * (P + G) + C;
        total  = b * L;
        pulses = 0;
        prev_iw = 1'b0;
        conti  = 1'b1;
        set_cfg(m, b);
        EN_work = 1'b1;
        for (int t = 1; t <= total + 3; t++) begin
            @(negedge CLK);
            if (t == 3) set_cfg($urandom_range(1, 99), $urandom_range(1, 99));
            u = t - 1;
            if (u >= total) begin
                exp_iw = 1'b0; exp_done = 1'b1; exp_busy = 1'b0;
                exp_pill = 0; exp_bot = b;
            end else begin
                bi = u / L;
                r  = u % L;
                exp_done = 1'b0; exp_busy = 1'b1; exp_bot = bi;
                if (r < m * (P + G)) begin
                    exp_pill = r / (P + G) + 1;
                    exp_iw   = (r % (P + G)) < P;
                end else begin
                    exp_pill = m;
                    exp_iw   = 1'b0;
                end
            end
            exp_v = {exp_iw, exp_done, exp_busy, to_bcd(exp_pill), to_bcd(exp_bot)};
            obs_v = {isWork, done, busy, pillH, pillL, bottleH, bottleL};
            check(tag, 32'(obs_v), 32'(exp_v));
            if (isWork && !prev_iw) pulses++;
            prev_iw = isWork;
        end
        check({tag, "_pulses"}, 32'(pulses), 32'(m * b));
        go_idle();
    endtask

    initial begin
        int   pulses, k;
        logic seen, prev_iw, found;

        RST_n = 1'b0; EN_work = 1'b0; conti = 1'b1; allFull = 1'b0;
        set_cfg(0, 0);
        #1;
        check("reset_outputs", 32'({isWork, pillH, pillL, bottleH, bottleL, busy, done, cfg_err}), 32'h0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Test-plan batches, then randomized ones
        run_model(3, 2, "batch_3x2");
        run_model(12, 1, "batch_12x1");
        for (int i = 0; i < 4; i++) begin
            run_model($urandom_range(1, 15), $urandom_range(1, 3), "batch_rand");
        end

        // conti=0: wait indefinitely in CHANGE, leave two cycles after the rise
        conti = 1'b0; set_cfg(2, 2); EN_work = 1'b1;
        pulses = 0; prev_iw = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (isWork && !prev_iw) pulses++;
            prev_iw = isWork;
        end
        check("chg_wait_state", 32'({isWork, busy, done, pillH, pillL, bottleH, bottleL}),
              32'({1'b0, 1'b1, 1'b0, 8'h02, 8'h00}));
        conti = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 2 && !found; t++) begin
            @(negedge CLK);
            if (isWork) found = 1'b1;
        end
        check("chg_resume_2cyc", 32'(found), 32'h1);
        check("chg_resume_tally", 32'({pillH, pillL, bottleH, bottleL}), 32'h0101);
        prev_iw = 1'b1; pulses++;
        k = 0;
        while (!done && k < 200) begin
            @(negedge CLK);
            if (isWork && !prev_iw) pulses++;
            prev_iw = isWork;
            k++;
        end
        check("chg_done", 32'(done), 32'h1);
        check("chg_final_tally", 32'({pillH, pillL, bottleH, bottleL}), 32'h0002);
        check("chg_pulses", 32'(pulses), 32'd4);
        repeat (5) @(negedge CLK);
        check("chg_no_extra_bottle", 32'({bottleH, bottleL}), 32'h02);
        go_idle();

        // Pause in the middle of the second pulse
        conti = 1'b1; set_cfg(3, 1); EN_work = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            @(negedge CLK);
            if (isWork && {pillH, pillL} == 8'h02) found = 1'b1;
        end
        check("pause_find_pulse2", 32'(found), 32'h1);
        EN_work = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (isWork) seen = 1'b1;
        end
        check("pause_no_pulse", 32'(seen), 32'h0);
        check("pause_tally", 32'({busy, pillH, pillL, bottleH, bottleL}), 32'h10200);
        EN_work = 1'b1;
        @(negedge CLK);
        check("pause_resume_pulse", 32'({isWork, pillH, pillL}), 32'h102);
        @(negedge CLK);
        check("pause_pulse_width", 32'(isWork), 32'h0);
        pulses = 0; prev_iw = 1'b0; k = 0;
        while (!done && k < 100) begin
            @(negedge CLK);
            if (isWork && !prev_iw) pulses++;
            prev_iw = isWork;
            k++;
        end
        check("pause_rest_pulses", 32'(pulses), 32'd1);
        check("pause_final", 32'({done, pillH, pillL, bottleH, bottleL}), 32'h10001);
        go_idle();

        // allFull during the first GAP
        set_cfg(3, 5); EN_work = 1'b1;
        repeat (2) @(negedge CLK);
        allFull = 1'b1;
        @(negedge CLK);
        check("allfull_done", 32'({done, busy, isWork, pillH, pillL, bottleH, bottleL}),
              32'({3'b100, 8'h01, 8'h00}));
        seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (isWork || !done) seen = 1'b1;
        end
        check("allfull_hold", 32'({seen, pillH, pillL, bottleH, bottleL}), 32'h00100);
        go_idle();

        // Invalid configurations never start
        maxL = 4'hA; maxH = 4'h0; botL = 4'h1; botH = 4'h0; EN_work = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (isWork || busy) seen = 1'b1;
        end
        check("cfg_bad_digit", 32'({cfg_err, seen}), 32'h2);
        set_cfg(3, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (isWork || busy) seen = 1'b1;
        end
        check("cfg_zero_bot", 32'({cfg_err, seen}), 32'h2);
        EN_work = 1'b0; set_cfg(3, 2);
        repeat (2) @(negedge CLK);
        check("cfg_ok_clears", 32'(cfg_err), 32'h0);

        // Asynchronous reset mid-batch
        EN_work = 1'b1;
        repeat (14) @(negedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        check("async_reset", 32'({isWork, pillH, pillL, bottleH, bottleL, busy, done, cfg_err}), 32'h0);
        EN_work = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        check("after_reset_idle", 32'({busy, done, isWork}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
